// File: rtl/spram_fifo_ctrl_pkg.sv
// Shared definitions for the single-port-RAM FIFO controller.
//  DW_DEFAULT / AW_DEFAULT : default data and address widths (match the 256x8 RAM)
//  DEPTH                   : number of RAM entries for the default address width
//  ram_op_e                : encoding of the RAM wr pin (OP_RD = 0, OP_WR = 1)
package spram_fifo_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int AW_DEFAULT = 8;
  localparam int DEPTH      = 2 ** AW_DEFAULT;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } ram_op_e;

endpackage

// File: rtl/spram_fifo_ctrl_if.sv
// Bundle of every signal between the FIFO controller and its neighbours.
//  Write stream : in_valid, in_ready, in_data
//  Read stream  : out_valid, out_ready, out_data
//  RAM side     : ram_addr, ram_wdata, ram_wr, ram_rdata
//  Status/debug : count (entries held in RAM), rd_inflight (RAM read in flight)
//
// Handshake rule for both streams: a word transfers on a rising clk edge where
// valid && ready are both 1. A source that raises valid holds it and its data
// stable until that transfer happens; ready may change freely.
//
// Modports: slave = the controller, master = the surrounding logic / bench.
interface spram_fifo_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 8
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wr;
  logic [DW-1:0] ram_rdata;
  logic [AW:0]   count;
  logic          rd_inflight;

  modport slave (
    input  in_valid, in_data, out_ready, ram_rdata,
    output in_ready, out_valid, out_data, ram_addr, ram_wdata, ram_wr,
           count, rd_inflight
  );

  modport master (
    output in_valid, in_data, out_ready, ram_rdata,
    input  in_ready, out_valid, out_data, ram_addr, ram_wdata, ram_wr,
           count, rd_inflight
  );

endinterface

// File: rtl/spram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM with a registered read port.
// Only one RAM operation per cycle, so reads and writes are arbitrated:
// a read is issued whenever RAM holds data and the output register is free,
// and that read beats any push in the same cycle.
//
// Ports:
//  clk   : rising-edge clock
//  rst_n : asynchronous active-low reset (RAM contents are not cleared)
//  bus   : spram_fifo_ctrl_if.slave (write stream, read stream, RAM pins,
//          entry count and rd_inflight debug flag)
//
// Read pipeline: issue cycle (RAM address = rd_ptr) -> capture cycle
// (ram_rdata -> out_data) -> out_valid held until popped. The next read can
// only issue after the pop, so sustained pop rate is one word per 3 cycles.
module spram_fifo_ctrl
  import spram_fifo_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  spram_fifo_ctrl_if.slave bus
);

  localparam logic [AW:0] FULL = (AW+1)'(2 ** AW);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          rd_inflight_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;

  logic rd_issue;
  logic in_ready_c;
  logic push;

  assign rd_issue   = (count_q != '0) && !rd_inflight_q && !out_valid_q;
  assign in_ready_c = (count_q != FULL) && !rd_issue;
  // rst_n gating keeps the un-reset RAM from being written while reset is held.
  assign push       = bus.in_valid && in_ready_c && rst_n;

  assign bus.in_ready    = in_ready_c;
  assign bus.ram_wr      = push ? OP_WR : OP_RD;
  // Idle cycles also present rd_ptr; the resulting read data is never captured.
  assign bus.ram_addr    = push ? wr_ptr : rd_ptr;
  assign bus.ram_wdata   = bus.in_data;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.count       = count_q;
  assign bus.rd_inflight = rd_inflight_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      rd_inflight_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
    end else begin
      // rd_issue and push are mutually exclusive, so count moves by one at most.
      if (rd_issue) begin
        rd_ptr  <= rd_ptr + AW'(1);
        count_q <= count_q - (AW+1)'(1);
      end else if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        count_q <= count_q + (AW+1)'(1);
      end

      rd_inflight_q <= rd_issue;

      // A capture can only follow an issue, which required out_valid = 0,
      // so capture and pop never coincide.
      if (rd_inflight_q) begin
        out_data_q  <= bus.ram_rdata;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Directed bench for spram_fifo_ctrl paired with a behavioural 256x8
// single-port RAM (registered read data, no read on write cycles).
module tb_spram_fifo_ctrl;
  import spram_fifo_pkg::*;

  localparam int DW = DW_DEFAULT;
  localparam int AW = AW_DEFAULT;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spram_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  spram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- RAM model ----------------
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_wdata;
    else            ram_q <= mem[bus.ram_addr];
  end
  assign bus.ram_rdata = ram_q;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        done = 1'b1;
        exp_q.push_back(d);
      end
      step();
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL push_timeout: data %h not accepted within 64 cycles", d);
    end
  endtask

  task automatic pop_word(output logic [DW-1:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        d  = bus.out_data;
      end
      step();
    end
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = DW'($urandom_range(0, 255));
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
      checks++; if (bus.count !== 9'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", bus.count); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      checks++; if (bus.ram_wr !== 1'b0) begin failures++; $display("FAIL reset_ram_wr: got %b want 0", bus.ram_wr); end
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_push();
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA5;
    bus.out_ready = 1'b1;
    @(negedge clk); // cycle 0: write to address 0
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL single_c0_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.ram_wr !== 1'b1) begin failures++; $display("FAIL single_c0_ram_wr: got %b want 1", bus.ram_wr); end
    checks++; if (bus.ram_addr !== 8'd0) begin failures++; $display("FAIL single_c0_ram_addr: got %0d want 0", bus.ram_addr); end
    step();
    bus.in_valid = 1'b0;
    @(negedge clk); // cycle 1: read issue from address 0
    checks++; if (bus.ram_wr !== 1'b0) begin failures++; $display("FAIL single_c1_ram_wr: got %b want 0", bus.ram_wr); end
    checks++; if (bus.ram_addr !== 8'd0) begin failures++; $display("FAIL single_c1_ram_addr: got %0d want 0", bus.ram_addr); end
    checks++; if (bus.count !== 9'd1) begin failures++; $display("FAIL single_c1_count: got %0d want 1", bus.count); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL single_c1_in_ready: got %b want 0", bus.in_ready); end
    step();
    @(negedge clk); // cycle 2: capture
    checks++; if (bus.count !== 9'd0) begin failures++; $display("FAIL single_c2_count: got %0d want 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_c2_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.rd_inflight !== 1'b1) begin failures++; $display("FAIL single_c2_inflight: got %b want 1", bus.rd_inflight); end
    step();
    @(negedge clk); // cycle 3: data presented
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_c3_out_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 8'hA5) begin failures++; $display("FAIL single_c3_out_data: got %h want a5", bus.out_data); end
    step();
    @(negedge clk); // popped at the previous edge
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_c4_out_valid: got %b want 0", bus.out_valid); end
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_full();
    int wr_cycles = 0;
    int accepted  = 0;
    int late_ready = 0;
    logic [DW-1:0] nxt = 8'h00;
    logic [DW-1:0] got;
    logic [DW-1:0] exp;
    bit ok;
    exp_q.delete();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = nxt;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.ram_wr) wr_cycles++;
      if (bus.in_ready) begin
        accepted++;
        exp_q.push_back(nxt);
        nxt++;
      end
      if (i >= 280 && bus.in_ready) late_ready++;
      step();
      bus.in_data = nxt;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    // 256 words fill the RAM; one more was written earlier and already sits in out_data.
    checks++; if (wr_cycles != 257) begin failures++; $display("FAIL full_ram_writes: got %0d want 257", wr_cycles); end
    checks++; if (accepted != 257) begin failures++; $display("FAIL full_accepted: got %0d want 257", accepted); end
    checks++; if (late_ready != 0) begin failures++; $display("FAIL full_in_ready_held: in_ready high %0d times want 0", late_ready); end
    checks++; if (bus.count !== 9'd256) begin failures++; $display("FAIL full_count: got %0d want 256", bus.count); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL full_out_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL full_out_data: got %h want 00", bus.out_data); end
    step();
    for (int i = 0; i < 257; i++) begin
      pop_word(got, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp) begin
        failures++;
        $display("FAIL full_drain[%0d]: got %h (valid seen %0d) want %h", i, got, ok, exp);
      end
    end
    @(negedge clk);
    checks++; if (bus.count !== 9'd0) begin failures++; $display("FAIL full_drained_count: got %0d want 0", bus.count); end
    step();
  endtask

  task automatic test_wrap();
    int sent = 0;
    int recv = 0;
    logic [DW-1:0] exp;
    exp_q.delete();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = '0;
    for (int cyc = 0; cyc < 4000 && recv < 600; cyc++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bus.in_data);
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (bus.out_data !== exp) begin
          failures++;
          $display("FAIL wrap_data[%0d]: got %h want %h", recv, bus.out_data, exp);
        end
        recv++;
      end
      step();
      bus.in_valid = (sent < 600);
      bus.in_data  = DW'(sent);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++; if (recv != 600) begin failures++; $display("FAIL wrap_received: got %0d want 600", recv); end
    checks++; if (bus.count !== 9'd0) begin failures++; $display("FAIL wrap_count: got %0d want 0", bus.count); end
    step();
  endtask

  task automatic test_contention();
    logic [DW-1:0] got;
    logic [DW-1:0] exp;
    bit ok;
    exp_q.delete();
    bus.out_ready = 1'b0;
    push_word(8'h10);
    push_word(8'h11);
    push_word(8'h12);
    push_word(8'h13);
    @(negedge clk);
    checks++; if (bus.count !== 9'd3) begin failures++; $display("FAIL cont_setup_count: got %0d want 3", bus.count); end
    checks++; if (bus.out_data !== 8'h10) begin failures++; $display("FAIL cont_setup_out_data: got %h want 10", bus.out_data); end
    // pop the head word at the next edge
    bus.out_ready = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h14;
    @(negedge clk); // count=3, out_valid=0: read must win
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL cont_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL cont_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.ram_wr !== 1'b0) begin failures++; $display("FAIL cont_ram_wr: got %b want 0", bus.ram_wr); end
    step();
    @(negedge clk); // capture cycle: the held push goes in
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL cont_next_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.ram_wr !== 1'b1) begin failures++; $display("FAIL cont_next_ram_wr: got %b want 1", bus.ram_wr); end
    if (bus.in_ready) exp_q.push_back(8'h14);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.count !== 9'd3) begin failures++; $display("FAIL cont_after_count: got %0d want 3", bus.count); end
    step();
    for (int i = 0; i < 4; i++) begin
      pop_word(got, ok);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (!ok || got !== exp) begin
        failures++;
        $display("FAIL cont_drain[%0d]: got %h (valid seen %0d) want %h", i, got, ok, exp);
      end
    end
  endtask

  task automatic test_reset_inflight();
    bit found = 1'b0;
    bit ok;
    int seen_valid = 0;
    logic [DW-1:0] got;
    exp_q.delete();
    bus.out_ready = 1'b0;
    push_word(8'h5A);
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.rd_inflight) found = 1'b1;
      else step();
    end
    checks++; if (!found) begin failures++; $display("FAIL rst_inflight_seen: got 0 want 1"); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid++;
      step();
    end
    @(negedge clk);
    checks++; if (seen_valid != 0) begin failures++; $display("FAIL rst_out_valid: high %0d cycles want 0", seen_valid); end
    checks++; if (bus.count !== 9'd0) begin failures++; $display("FAIL rst_count: got %0d want 0", bus.count); end
    step();
    push_word(8'hC3);
    pop_word(got, ok);
    checks++;
    if (!ok || got !== 8'hC3) begin
      failures++;
      $display("FAIL rst_readback: got %h (valid seen %0d) want c3", got, ok);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_push();
    test_full();
    test_wrap();
    test_contention();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
